// File: rtl/ampel_ctrl.sv
// Traffic-light sequencer for one car signal and one pedestrian crossing.
// It has a tick prescaler, a latch for pedestrian requests, night-flash mode and a countdown digit.
module ampel_ctrl #(
  parameter int TICK_DIV = 12000000,
  parameter int T_GRN    = 9,
  parameter int T_YEL    = 3,
  parameter int T_PED    = 7,
  parameter int T_CLR    = 2,
  parameter int T_RY     = 1
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       REQ,
  input  logic       NIGHT,
  output logic       CAR_R,
  output logic       CAR_Y,
  output logic       CAR_G,
  output logic       PED_R,
  output logic       PED_G,
  output logic       WAIT,
  output logic [3:0] DIGIT,
  output logic       TICK
);

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    CAR_GO, CAR_STOP, PED_GO, ALL_RED, CAR_PREP, FLASH
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   presc_reg;
  logic            tick;
  logic [1:0]      async_in;
  logic            req_s, night_s, req_dly_reg, req_rise;
  logic            req_pend_reg, req_pend_next;
  logic            night_pend_reg, night_pend_next;
  logic            flash_y_reg, flash_y_next;
  logic            entering_ped;
  logic [3:0]      digit_reg, digit_next;
  logic [4:0]      lamp_reg, lamp_next;   // {CAR_R, CAR_Y, CAR_G, PED_R, PED_G}

  function automatic logic [3:0] phase_len(input state_t s);
    case (s)
      CAR_GO:   return 4'(T_GRN);
      CAR_STOP: return 4'(T_YEL);
      PED_GO:   return 4'(T_PED);
      CAR_PREP: return 4'(T_RY);
      FLASH:    return 4'd15;
      default:  return 4'(T_CLR);
    endcase
  endfunction

  assign tick     = (presc_reg == PRESC_LAST);
  assign async_in = {NIGHT, REQ};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg, sync_reg;
      always_ff @(posedge CLK) begin
        if (!RES) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
        end
      end
    end
  endgenerate

  assign req_s    = g_sync[0].sync_reg;
  assign night_s  = g_sync[1].sync_reg;
  assign req_rise = req_s & ~req_dly_reg;

  always_comb begin
    state_next      = state_reg;
    digit_next      = digit_reg;
    night_pend_next = night_pend_reg;
    flash_y_next    = flash_y_reg;
    if (tick) begin
      case (state_reg)
        CAR_GO:
          if (digit_reg == 4'd0) begin
            if (req_pend_reg) begin
              state_next = CAR_STOP;
            end else if (night_s) begin
              state_next      = CAR_STOP;
              night_pend_next = 1'b1;
            end
          end
        CAR_STOP: if (digit_reg == 4'd0) state_next = night_pend_reg ? ALL_RED : PED_GO;
        PED_GO:   if (digit_reg == 4'd0) state_next = ALL_RED;
        ALL_RED:  if (digit_reg == 4'd0) state_next = (night_pend_reg || night_s) ? FLASH : CAR_PREP;
        CAR_PREP: if (digit_reg == 4'd0) state_next = CAR_GO;
        FLASH:
          if (!night_s) state_next = ALL_RED;
          else          flash_y_next = ~flash_y_reg;
        default:  state_next = ALL_RED;
      endcase
      // No state ever transitions to itself, so a change of state marks a phase entry
      if (state_next != state_reg) begin
        digit_next = phase_len(state_next);
        if (state_next == FLASH) begin
          night_pend_next = 1'b0;
          flash_y_next    = 1'b1;
        end
      end else if (state_reg != FLASH && digit_reg != 4'd0) begin
        digit_next = digit_reg - 4'd1;
      end
    end

    entering_ped  = (state_next == PED_GO) && (state_reg != PED_GO);
    req_pend_next = entering_ped ? 1'b0 : (req_pend_reg | req_rise);

    case (state_next)
      CAR_GO:   lamp_next = 5'b00110;
      CAR_STOP: lamp_next = 5'b01010;
      PED_GO:   lamp_next = 5'b10001;
      CAR_PREP: lamp_next = 5'b11010;
      FLASH:    lamp_next = {1'b0, flash_y_next, 3'b000};
      default:  lamp_next = 5'b10010;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RES) begin
      state_reg      <= ALL_RED;
      presc_reg      <= '0;
      digit_reg      <= 4'(T_CLR);
      req_pend_reg   <= 1'b0;
      night_pend_reg <= 1'b0;
      flash_y_reg    <= 1'b0;
      req_dly_reg    <= 1'b0;
      lamp_reg       <= 5'b10010;
    end else begin
      state_reg      <= state_next;
      presc_reg      <= tick ? '0 : presc_reg + PW'(1);
      digit_reg      <= digit_next;
      req_pend_reg   <= req_pend_next;
      night_pend_reg <= night_pend_next;
      flash_y_reg    <= flash_y_next;
      req_dly_reg    <= req_s;
      lamp_reg       <= lamp_next;
    end
  end

  assign {CAR_R, CAR_Y, CAR_G, PED_R, PED_G} = lamp_reg;
  assign WAIT  = req_pend_reg;
  assign DIGIT = digit_reg;
  assign TICK  = tick;

endmodule

// File: tb/tb_ampel_ctrl.sv
// Bench for ampel_ctrl: directed phases followed by random REQ/NIGHT traffic.
// Every cycle is checked against a model that steps through phases by counting ticks.
module tb_ampel_ctrl;

  localparam int TD = 4;
  localparam int P_GO = 0, P_STOP = 1, P_PED = 2, P_RED = 3, P_PREP = 4, P_FLASH = 5;

  logic       CLK = 1'b0;
  logic       RES = 1'b0;
  logic       REQ = 1'b0;
  logic       NIGHT = 1'b0;
  logic       CAR_R, CAR_Y, CAR_G, PED_R, PED_G, WAIT, TICK;
  logic [3:0] DIGIT;

  ampel_ctrl #(.TICK_DIV(TD)) dut (
    .CLK(CLK), .RES(RES), .REQ(REQ), .NIGHT(NIGHT),
    .CAR_R(CAR_R), .CAR_Y(CAR_Y), .CAR_G(CAR_G), .PED_R(PED_R), .PED_G(PED_G),
    .WAIT(WAIT), .DIGIT(DIGIT), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // The model counts the ticks still remaining in the current phase, including the current tick
  int    dur[6]   = '{9, 3, 7, 2, 1, 0};
  string pname[6] = '{"CAR_GO", "CAR_STOP", "PED_GO", "ALL_RED", "CAR_PREP", "FLASH"};
  int    m_ph, m_left, m_cnt;
  bit    m_pend, m_npend, m_fy;
  bit [2:0] rh;
  bit [1:0] nh;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] lamp_of(input int ph, input bit fy);
    case (ph)
      P_GO:    return 5'b00110;
      P_STOP:  return 5'b01010;
      P_PED:   return 5'b10001;
      P_PREP:  return 5'b11010;
      P_FLASH: return {1'b0, fy, 3'b000};
      default: return 5'b10010;
    endcase
  endfunction

  task automatic model_edge(input bit res, input bit req, input bit night);
    bit tk, ns, rise;
    int nxt;
    if (!res) begin
      m_ph = P_RED; m_left = dur[P_RED] + 1; m_cnt = 0;
      m_pend = 0; m_npend = 0; m_fy = 0; rh = '0; nh = '0;
      return;
    end
    tk   = (m_cnt == TD - 1);
    ns   = nh[1];
    rise = rh[1] & ~rh[2];
    nxt  = -1;
    m_cnt = (m_cnt + 1) % TD;
    if (tk) begin
      if (m_ph == P_FLASH) begin
        if (!ns) nxt = P_RED;
        else     m_fy = !m_fy;
      end else if (m_left > 1) begin
        m_left--;
      end else begin
        case (m_ph)
          P_GO:   if (m_pend) nxt = P_STOP;
                  else if (ns) begin nxt = P_STOP; m_npend = 1; end
          P_STOP: nxt = m_npend ? P_RED : P_PED;
          P_PED:  nxt = P_RED;
          P_RED:  nxt = (m_npend || ns) ? P_FLASH : P_PREP;
          default: nxt = P_GO;
        endcase
      end
    end
    m_pend = m_pend | rise;
    if (nxt == P_PED) m_pend = 0;
    if (nxt >= 0) begin
      $display("t=%0t phase %s -> %s", $time, pname[m_ph], pname[nxt]);
      m_ph   = nxt;
      m_left = dur[nxt] + 1;
      if (nxt == P_FLASH) begin m_npend = 0; m_fy = 1; end
    end
    rh = {rh[1:0], req};
    nh = {nh[0], night};
  endtask

  task automatic cyc(input bit res, input bit req, input bit night);
    @(negedge CLK);
    RES = res; REQ = req; NIGHT = night;
    @(posedge CLK);
    model_edge(res, req, night);
    #1;
    check("lamps", {CAR_R, CAR_Y, CAR_G, PED_R, PED_G}, lamp_of(m_ph, m_fy));
    check("digit", DIGIT, (m_ph == P_FLASH) ? 15 : m_left - 1);
    check("wait", WAIT, m_pend);
    check("tick", TICK, m_cnt == TD - 1);
    check("safety", PED_G & (CAR_G | CAR_Y), 0);
  endtask

  task automatic run_to(input int ph, input int maxc, input bit req, input bit night, input string tag);
    int n = 0;
    while (m_ph != ph && n < maxc) begin
      cyc(1, req, night);
      n++;
    end
    check(tag, {CAR_R, CAR_Y, CAR_G, PED_R, PED_G}, lamp_of(ph, 1'b1));
  endtask

  initial begin
    bit r, nt;
    int n;
    repeat (3) cyc(0, 0, 0);
    check("rst_lamps", {CAR_R, CAR_Y, CAR_G, PED_R, PED_G}, 5'b10010);
    check("rst_digit", DIGIT, 2);
    check("rst_wait", WAIT, 0);
    check("rst_tick", TICK, 0);

    run_to(P_PREP, 20, 0, 0, "to_prep");
    check("prep_digit", DIGIT, 1);
    run_to(P_GO, 20, 0, 0, "to_go");
    check("go_digit", DIGIT, 9);

    n = 0;
    while (DIGIT != 4'd5 && n < 40) begin cyc(1, 0, 0); n++; end
    check("go_digit5", DIGIT, 5);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("wait_set", WAIT, 1);
    run_to(P_STOP, 60, 0, 0, "to_stop");
    run_to(P_PED, 30, 0, 0, "to_ped");
    check("ped_wait", WAIT, 0);
    check("ped_digit", DIGIT, 7);
    n = 0;
    while (PED_G && n < 100) begin cyc(1, 0, 0); n++; end
    check("ped_len", n, 8 * TD);
    check("ped_after", {CAR_R, CAR_Y, CAR_G, PED_R, PED_G}, 5'b10010);

    run_to(P_GO, 100, 0, 0, "to_go2");
    repeat (50 * TD) cyc(1, 0, 0);
    check("go_hold", CAR_G, 1);
    check("go_hold_digit", DIGIT, 0);

    run_to(P_STOP, 40, 0, 1, "night_stop");
    run_to(P_RED, 40, 0, 1, "night_red");
    run_to(P_FLASH, 40, 0, 1, "night_flash");
    check("flash_digit", DIGIT, 15);
    repeat (3 * TD) cyc(1, 0, 1);
    run_to(P_RED, 20, 0, 0, "flash_exit");
    check("exit_digit", DIGIT, 2);

    cyc(1, 1, 0);
    run_to(P_PED, 300, 0, 0, "to_ped2");
    repeat (5) cyc(1, 0, 0);
    cyc(0, 0, 0);
    check("midrst_lamps", {CAR_R, CAR_Y, CAR_G, PED_R, PED_G}, 5'b10010);
    check("midrst_digit", DIGIT, 2);
    check("midrst_wait", WAIT, 0);

    r = 0; nt = 0;
    repeat (2000 * TD) begin
      if ($urandom_range(0, 19) == 0)  r  = !r;
      if ($urandom_range(0, 399) == 0) nt = !nt;
      cyc(1, r, nt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ampel_ctrl.md
Name: ampel_ctrl

Overview:
- Traffic-light sequencer for one car signal and one pedestrian crossing with a request button.
- Drives the lamp outputs and a 4-bit countdown digit, DIGIT, that feeds the existing 7-segment decoder stage (A input) directly.
- Contains its own tick prescaler, request latch and night-flash mode.
- Sits in the Ampel top level in place of the running-light source on the 4-bit display bus.

Parameters:
TICK_DIV, 12000000, clock cycles per countdown tick (1 s at 12 MHz); minimum 2
T_GRN, 9, minimum car-green duration in ticks (0..15)
T_YEL, 3, car-yellow duration in ticks (0..15)
T_PED, 7, pedestrian-green duration in ticks (0..15)
T_CLR, 2, all-red clearance duration in ticks (0..15)
T_RY, 1, car red-yellow duration in ticks (0..15)

Ports:
CLK  input  1  system clock, all logic rising-edge
RES  input  1  synchronous reset, active low
REQ  input  1  pedestrian button, asynchronous, active high, already debounced
NIGHT  input  1  night-flash mode request, asynchronous, active high
CAR_R  output  1  car red lamp
CAR_Y  output  1  car yellow lamp
CAR_G  output  1  car green lamp
PED_R  output  1  pedestrian red lamp
PED_G  output  1  pedestrian green lamp
WAIT  output  1  "request registered" indicator
DIGIT  output  4  remaining ticks of current phase, binary 0..15, to 7-seg decoder
TICK  output  1  one-cycle tick strobe (debug / display blink)

Behaviour:
- Reset: RES=0 sampled at a CLK edge. Registers take these values:
  - state=ALL_RED, prescaler=0, DIGIT=T_CLR, REQ_PEND=0, synchronizers=0.
  - Outputs: CAR_R=1, PED_R=1, all other lamps 0, WAIT=0, TICK=0.
- Reset mid-phase aborts the phase immediately. No partial state is kept.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - TICK=1 for exactly the cycle in which the count equals TICK_DIV-1.
- REQ and NIGHT each pass through a 2-FF synchronizer.
- Request latch:
  - A rising edge of synchronized REQ sets REQ_PEND.
  - REQ_PEND clears on the cycle the FSM enters PED_GO. If a set and a clear coincide, the clear wins.
  - WAIT = REQ_PEND.
- Countdown:
  - On each state entry, DIGIT loads the new state's duration.
  - On each TICK with DIGIT>0, DIGIT decrements.
  - The phase ends on a TICK with DIGIT==0, so a phase lasts duration+1 ticks.
- FSM states and transitions. All transitions happen only on a TICK cycle.
  - CAR_GO (CAR_G, PED_R):
    - DIGIT==0 and REQ_PEND -> CAR_STOP.
    - DIGIT==0 and NIGHT_s and not REQ_PEND -> CAR_STOP, with night pending.
    - Otherwise DIGIT holds at 0.
  - CAR_STOP (CAR_Y, PED_R): end -> ALL_RED if night pending, else PED_GO.
  - PED_GO (CAR_R, PED_G): end -> ALL_RED.
  - ALL_RED (CAR_R, PED_R): end -> FLASH if night pending or NIGHT_s, else CAR_PREP.
  - CAR_PREP (CAR_R, CAR_Y, PED_R): end -> CAR_GO.
  - FLASH:
    - CAR_Y toggles on every TICK. All other lamps are 0. DIGIT=15 and is not decremented.
    - On a TICK with NIGHT_s==0 -> ALL_RED, then normal sequence.
    - REQ_PEND may still set during FLASH but is not serviced there.
- Night pending is a 1-bit flag. It sets on the CAR_GO -> CAR_STOP transition when NIGHT_s=1 and clears on entry to FLASH.
- Outputs are registered (Moore). Lamps and DIGIT change in the cycle after the TICK that causes the transition.
- Safety invariant: CAR_G or CAR_Y is never 1 together with PED_G, in any cycle.
- A duration of 0 is legal: the phase lasts exactly 1 tick.

Test Plan:
- TICK_DIV=4, defaults; release RES after 3 cycles. Required response:
  - Lamps CAR_R=PED_R=1, DIGIT=2.
  - TICK every 4th cycle.
  - After 3 ticks CAR_PREP, DIGIT=1; after 2 more ticks CAR_GO, DIGIT=9.
- No REQ. Required response: CAR_GO, DIGIT reaches 0 and stays; CAR_G remains 1 for 50 ticks.
- Pulse REQ for 1 cycle at DIGIT=5 in CAR_GO. Required response:
  - WAIT=1 within 3 cycles.
  - CAR_STOP after DIGIT 0 plus 1 tick.
  - PED_GO after 4 ticks with WAIT=0, PED_G=1, DIGIT=7.
  - PED_G lasts 8 ticks, then ALL_RED.
- Set NIGHT in CAR_GO with no REQ. Required response:
  - Sequence CAR_STOP -> ALL_RED -> FLASH.
  - CAR_Y toggles each tick, DIGIT=15.
  - Drop NIGHT: next tick ALL_RED, DIGIT=2.
- Assert RES=0 for 1 cycle during PED_GO. Required response: next cycle all reset values (CAR_R=PED_R=1, DIGIT=2, WAIT=0).
- Run 2000 ticks with random REQ/NIGHT. Required response: no cycle with PED_G & (CAR_G|CAR_Y); DIGIT never exceeds 15.
